// File: rtl/scrambler_frame_ctrl.sv
// Frame controller for the 12-bit additive TX scrambler: raw header pass-through,
// LFSR-scrambled payload, per-frame reseed, frame counting and framing-error pulses.
module scrambler_frame_ctrl #(
    parameter int          HDR_LEN = 16,
    parameter logic [11:0] SEED    = 12'h14D,
    parameter int          CNT_W   = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             SCR_EN_I,
    input  logic             S_VALID_I,
    output logic             S_READY_O,
    input  logic             S_BIT_I,
    input  logic             S_SOF_I,
    input  logic             S_EOF_I,
    output logic             M_VALID_O,
    input  logic             M_READY_I,
    output logic             M_BIT_O,
    output logic             M_SOF_O,
    output logic             M_EOF_O,
    output logic             BUSY_O,
    output logic [CNT_W-1:0] FRAME_CNT_O,
    output logic             ERR_O
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } state_t;

    localparam logic [7:0] HDR_LAST = 8'(HDR_LEN);

    function automatic logic lfsr_fb(input logic [11:0] q);
        return q[10] ^ q[3] ^ q[0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [11:0]        r_lfsr;
    logic [11:0]        w_lfsr_nxt;
    logic [7:0]         r_hdr_cnt;
    logic [7:0]         w_hdr_nxt;
    logic [7:0]         w_hdr_inc;
    logic               r_scr_en;
    logic               w_scr_en_nxt;
    logic               w_fb;
    logic               w_in_xfer;
    logic               w_emit;
    logic               w_out_bit;
    logic               w_err;
    logic               w_cnt_inc;
    logic               r_m_valid;
    logic               r_m_bit;
    logic               r_m_sof;
    logic               r_m_eof;
    logic               r_err;
    logic [CNT_W-1:0]   r_frame_cnt;

    assign w_fb      = lfsr_fb(r_lfsr);
    assign w_hdr_inc = r_hdr_cnt + 8'd1;
    assign S_READY_O = !r_m_valid | M_READY_I;
    assign w_in_xfer = S_VALID_I & S_READY_O;

    // Next-state, keystream and output-bit decode for the accepted input bit.
    always_comb begin
        w_state_nxt  = r_state;
        w_lfsr_nxt   = r_lfsr;
        w_hdr_nxt    = r_hdr_cnt;
        w_scr_en_nxt = r_scr_en;
        w_emit       = 1'b0;
        w_out_bit    = S_BIT_I;
        w_err        = 1'b0;
        w_cnt_inc    = 1'b0;
        if (w_in_xfer) begin
            if (S_SOF_I) begin
                // SOF always starts a fresh frame; mid-frame it also aborts the old one.
                w_err        = (r_state != ST_IDLE);
                w_lfsr_nxt   = SEED;
                w_scr_en_nxt = SCR_EN_I;
                w_emit       = 1'b1;
                if (S_EOF_I) begin
                    w_cnt_inc   = 1'b1;
                    w_hdr_nxt   = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hdr_nxt   = 8'd1;
                    w_state_nxt = (HDR_LAST == 8'd1) ? ST_PAY : ST_HDR;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_err = 1'b1;
                    end
                    ST_HDR: begin
                        w_emit    = 1'b1;
                        w_hdr_nxt = w_hdr_inc;
                        if (S_EOF_I) begin
                            w_err       = 1'b1;
                            w_cnt_inc   = 1'b1;
                            w_hdr_nxt   = 8'd0;
                            w_state_nxt = ST_IDLE;
                        end else if (w_hdr_inc == HDR_LAST) begin
                            w_state_nxt = ST_PAY;
                        end else begin
                            w_state_nxt = ST_HDR;
                        end
                    end
                    ST_PAY: begin
                        w_emit = 1'b1;
                        if (r_scr_en) begin
                            w_out_bit  = S_BIT_I ^ w_fb;
                            w_lfsr_nxt = {w_fb, r_lfsr[11:1]};
                        end else begin
                            w_out_bit  = S_BIT_I;
                        end
                        if (S_EOF_I) begin
                            w_cnt_inc   = 1'b1;
                            w_hdr_nxt   = 8'd0;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PAY;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_hdr_nxt   = 8'd0;
                    end
                endcase
            end
        end else begin
            w_emit = 1'b0;
        end
    end

    // Frame state, LFSR, header counter and latched scramble enable.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= SEED;
            r_hdr_cnt <= 8'd0;
            r_scr_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lfsr    <= w_lfsr_nxt;
            r_hdr_cnt <= w_hdr_nxt;
            r_scr_en  <= w_scr_en_nxt;
        end
    end

    // Output skid register; contents only change on a new accepted bit.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_m_valid <= 1'b0;
            r_m_bit   <= 1'b0;
            r_m_sof   <= 1'b0;
            r_m_eof   <= 1'b0;
        end else if (w_emit) begin
            r_m_valid <= 1'b1;
            r_m_bit   <= w_out_bit;
            r_m_sof   <= S_SOF_I;
            r_m_eof   <= S_EOF_I;
        end else if (M_READY_I) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

    // Frame counter and one-cycle error pulse.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign M_VALID_O   = r_m_valid;
    assign M_BIT_O     = r_m_bit;
    assign M_SOF_O     = r_m_sof;
    assign M_EOF_O     = r_m_eof;
    assign BUSY_O      = (r_state != ST_IDLE);
    assign FRAME_CNT_O = r_frame_cnt;
    assign ERR_O       = r_err;

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Self-checking bench for scrambler_frame_ctrl: directed scenarios plus randomized
// frames, compared cycle by cycle against a frame-level behavioural model.
module tb_scrambler_frame_ctrl;

    localparam int HDR_LEN = 16;
    localparam int SEED    = 'h14D;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        SCR_EN_I = 1'b0;
    logic        S_VALID_I = 1'b0;
    logic        S_READY_O;
    logic        S_BIT_I = 1'b0;
    logic        S_SOF_I = 1'b0;
    logic        S_EOF_I = 1'b0;
    logic        M_VALID_O;
    logic        M_READY_I = 1'b1;
    logic        M_BIT_O;
    logic        M_SOF_O;
    logic        M_EOF_O;
    logic        BUSY_O;
    logic [15:0] FRAME_CNT_O;
    logic        ERR_O;

    scrambler_frame_ctrl dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .SCR_EN_I(SCR_EN_I),
        .S_VALID_I(S_VALID_I), .S_READY_O(S_READY_O), .S_BIT_I(S_BIT_I),
        .S_SOF_I(S_SOF_I), .S_EOF_I(S_EOF_I),
        .M_VALID_O(M_VALID_O), .M_READY_I(M_READY_I), .M_BIT_O(M_BIT_O),
        .M_SOF_O(M_SOF_O), .M_EOF_O(M_EOF_O), .BUSY_O(BUSY_O),
        .FRAME_CNT_O(FRAME_CNT_O), .ERR_O(ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    int checks = 0;
    int failures = 0;

    // Reference model state: frame position, keystream, pending output.
    logic        m_busy, m_en, m_err;
    int          m_hdr, m_lfsr;
    logic [15:0] m_frames;
    logic        mv, mb, ms, me;
    logic        tog = 1'b0;
    logic        rec_q[$];
    logic        in_bits[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic next_key();
        int fb;
        fb = ((m_lfsr >> 10) ^ (m_lfsr >> 3) ^ m_lfsr) & 1;
        m_lfsr = (m_lfsr >> 1) | (fb << 11);
        return 1'(fb);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_en = 1'b0; m_err = 1'b0; m_hdr = 0; m_lfsr = SEED;
        m_frames = 16'd0; mv = 1'b0; mb = 1'b0; ms = 1'b0; me = 1'b0;
    endtask

    task automatic model_accept(input logic acc, input logic b, input logic sof,
                                input logic eof, input logic en, input logic rdy);
        logic emit, ob;
        emit = 1'b0; ob = b; m_err = 1'b0;
        if (acc) begin
            if (sof) begin
                m_err = m_busy; m_lfsr = SEED; m_en = en; m_hdr = 1; emit = 1'b1;
                if (eof) begin m_frames++; m_busy = 1'b0; end
                else m_busy = 1'b1;
            end else if (!m_busy) begin
                m_err = 1'b1;
            end else if (m_hdr < HDR_LEN) begin
                emit = 1'b1; m_hdr++;
                if (eof) begin m_err = 1'b1; m_frames++; m_busy = 1'b0; end
            end else begin
                emit = 1'b1;
                if (m_en) ob = b ^ next_key();
                if (eof) begin m_frames++; m_busy = 1'b0; end
            end
        end
        if (emit) begin mv = 1'b1; mb = ob; ms = sof; me = eof; end
        else if (rdy) mv = 1'b0;
    endtask

    task automatic check_outputs();
        chk("m_valid", 32'(M_VALID_O), 32'(mv));
        chk("busy", 32'(BUSY_O), 32'(m_busy));
        chk("frame_cnt", 32'(FRAME_CNT_O), 32'(m_frames));
        chk("err", 32'(ERR_O), 32'(m_err));
        if (mv) begin
            chk("m_bit", 32'(M_BIT_O), 32'(mb));
            chk("m_sof", 32'(M_SOF_O), 32'(ms));
            chk("m_eof", 32'(M_EOF_O), 32'(me));
        end
    endtask

    // One clock: drive at negedge, check ready, step model, check registered outputs.
    task automatic step(input logic v, input logic b, input logic sof, input logic eof,
                        input logic en, input logic rdy, output logic acc);
        logic exp_rdy;
        S_VALID_I = v; S_BIT_I = b; S_SOF_I = sof; S_EOF_I = eof;
        SCR_EN_I = en; M_READY_I = rdy;
        #1;
        exp_rdy = !mv | rdy;
        chk("s_ready", 32'(S_READY_O), 32'(exp_rdy));
        if (M_VALID_O === 1'b1 && rdy) rec_q.push_back(M_BIT_O);
        acc = v & exp_rdy;
        model_accept(acc, b, sof, eof, en, rdy);
        @(posedge CLK_I);
        @(negedge CLK_I);
        check_outputs();
    endtask

    task automatic do_reset();
        RST_I = 1'b1; S_VALID_I = 1'b0;
        @(posedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
        model_reset();
        check_outputs();
        chk("reset_m_valid", 32'(M_VALID_O), 32'd0);
        chk("reset_busy", 32'(BUSY_O), 32'd0);
    endtask

    // rmode 0: ready always; 1: random ready/valid; 2: ready toggles every cycle.
    task automatic send_bit(input logic b, input logic sof, input logic eof,
                            input logic en, input int rmode);
        logic acc, v, rdy;
        int budget;
        acc = 1'b0; budget = 0;
        while (!acc && budget < 50) begin
            if (rmode == 2) tog = ~tog;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 2) ? tog : ($urandom_range(0, 3) != 0);
            v   = (rmode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
            step(v, b, sof, eof, en, rdy, acc);
            budget++;
        end
        if (!acc) begin
            checks++; failures++;
            $error("FAIL handshake_timeout observed=0 expected=1");
        end
        in_bits.push_back(b);
    endtask

    task automatic send_frame(input int len, input int n_hdr_rand, input logic en,
                              input int rmode, input logic zero_pay);
        logic b;
        for (int i = 0; i < len; i++) begin
            b = (i < n_hdr_rand || !zero_pay) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_bit(b, i == 0, i == len - 1, en, rmode);
        end
    endtask

    task automatic flush();
        logic acc;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    logic ks [5];
    logic acc_d;
    int   n0;

    initial begin
        ks[0] = 1'b0; ks[1] = 1'b0; ks[2] = 1'b1; ks[3] = 1'b0; ks[4] = 1'b1;
        model_reset();
        @(negedge CLK_I);
        do_reset();
        chk("reset_frame_cnt", 32'(FRAME_CNT_O), 32'd0);
        chk("reset_err", 32'(ERR_O), 32'd0);

        // Scrambled frame with zero payload shows the raw keystream.
        rec_q.delete(); in_bits.delete();
        send_frame(21, HDR_LEN, 1'b1, 0, 1'b1);
        flush();
        chk("t1_len", 32'(rec_q.size()), 32'd21);
        for (int i = 0; i < 16; i++) chk("t1_hdr_raw", 32'(rec_q[i]), 32'(in_bits[i]));
        for (int i = 0; i < 5; i++) chk("t1_keystream", 32'(rec_q[16+i]), 32'(ks[i]));
        chk("t1_frame_cnt", 32'(FRAME_CNT_O), 32'd1);

        // Bypass: every bit identical to input.
        rec_q.delete(); in_bits.delete();
        send_frame(21, HDR_LEN, 1'b0, 0, 1'b0);
        flush();
        chk("t2_len", 32'(rec_q.size()), 32'd21);
        for (int i = 0; i < 21; i++) chk("t2_bypass", 32'(rec_q[i]), 32'(in_bits[i]));
        chk("t2_frame_cnt", 32'(FRAME_CNT_O), 32'd2);

        // Ready toggling every cycle must not alter the keystream.
        rec_q.delete(); in_bits.delete();
        send_frame(24, HDR_LEN, 1'b1, 2, 1'b1);
        flush();
        chk("t3_len", 32'(rec_q.size()), 32'd24);
        for (int i = 0; i < 5; i++) chk("t3_keystream", 32'(rec_q[16+i]), 32'(ks[i]));

        // Back-to-back frames: reseed at every SOF.
        rec_q.delete(); in_bits.delete();
        send_frame(21, HDR_LEN, 1'b1, 0, 1'b1);
        send_frame(21, HDR_LEN, 1'b1, 0, 1'b1);
        flush();
        chk("t4_len", 32'(rec_q.size()), 32'd42);
        for (int i = 0; i < 5; i++) chk("t4_reseed", 32'(rec_q[37+i]), 32'(ks[i]));

        // SOF after three payload bits aborts the frame.
        n0 = int'(FRAME_CNT_O);
        for (int i = 0; i < 19; i++) send_bit(1'b0, i == 0, 1'b0, 1'b1, 0);
        send_bit(1'b1, 1'b1, 1'b0, 1'b1, 0);
        chk("t5_err", 32'(ERR_O), 32'd1);
        chk("t5_busy", 32'(BUSY_O), 32'd1);
        for (int i = 1; i < 21; i++) send_bit(1'b0, 1'b0, i == 20, 1'b1, 0);
        flush();
        chk("t5_frame_cnt", 32'(FRAME_CNT_O), 32'(n0 + 1));

        // EOF on header bit 4: short frame counted and flagged.
        n0 = int'(FRAME_CNT_O);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, i == 4, 1'b1, 0);
        chk("t6_short_err", 32'(ERR_O), 32'd1);
        chk("t6_short_busy", 32'(BUSY_O), 32'd0);
        chk("t6_short_cnt", 32'(FRAME_CNT_O), 32'(n0 + 1));
        flush();

        // Stray bit in IDLE is dropped.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc_d);
        chk("t6_stray_err", 32'(ERR_O), 32'd1);
        chk("t6_stray_valid", 32'(M_VALID_O), 32'd0);

        // Single-bit frame in IDLE.
        n0 = int'(FRAME_CNT_O);
        send_bit(1'b1, 1'b1, 1'b1, 1'b1, 0);
        chk("t6_single_err", 32'(ERR_O), 32'd0);
        chk("t6_single_cnt", 32'(FRAME_CNT_O), 32'(n0 + 1));
        flush();

        // Reset mid-payload with an output bit pending.
        for (int i = 0; i < 18; i++) send_bit(1'b1, i == 0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc_d);
        do_reset();
        chk("t6_rst_cnt", 32'(FRAME_CNT_O), 32'd0);

        // Randomized frames, handshakes and stray bits.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) step(1'b1, 1'($urandom_range(0, 1)), 1'b0,
                                                1'($urandom_range(0, 1)), 1'b1, 1'b1, acc_d);
            send_frame($urandom_range(1, 40), 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2), 1'b0);
        end
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
